ibex_mult_pext_seq: RTL and testbench

IBEX_MULT_PEXT_SEQ -- requirements
Module: ibex_mult_pext_seq

---
 rtl/ibex_pkg_pext.sv | 5 +
 rtl/ibex_mult_pext_sat.sv | 17 +
 rtl/ibex_mult_pext_seq.sv | 96 +++++++++
 tb/tb_ibex_mult_pext_seq.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/ibex_pkg_pext.sv
// ibex_pkg_pext: shared FSM state type and rounding constant for the sequential P-ext multiplier
package ibex_pkg_pext;
    typedef enum logic [1:0] {IDLE, CYC1, CYC2} mult_seq_state_e;
    localparam logic [63:0] ROUND_C = 64'h0000_0000_8000_0000;
endpackage

// File: rtl/ibex_mult_pext_sat.sv
// ibex_mult_pext_sat: signed 32-bit add/sub with optional saturation of the 33-bit sum
module ibex_mult_pext_sat (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        sub,
    input  logic        sat,
    output logic [31:0] res,
    output logic        ov
);
    logic [32:0] sum;
    // overflow shows as disagreement between the two top bits of the 33-bit sum
    always_comb begin
        sum = sub ? {a[31], a} - {b[31], b} : {a[31], a} + {b[31], b};
        ov = sat & (sum[32] ^ sum[31]);
        res = ov ? (sum[32] ? 32'h8000_0000 : 32'h7fff_ffff) : sum[31:0];
    end
endmodule

// File: rtl/ibex_mult_pext_seq.sv
// ibex_mult_pext_seq: 1/2/3-cycle sequencer combining 33x16 partial products with optional accumulate
module ibex_mult_pext_seq
    import ibex_pkg_pext::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        mult_en_i,
    input  logic [1:0]  cycle_count_i,
    input  logic        accum_i,
    input  logic        sub_i,
    input  logic        sat_i,
    input  logic        round_i,
    input  logic        out_lo_i,
    input  logic [48:0] pp_i,
    input  logic [31:0] single_i,
    input  logic [31:0] rd_i,
    output logic        b_half_o,
    output logic [31:0] result_o,
    output logic        valid_o,
    output logic        ov_o
);
    mult_seq_state_e state_q, state_d;
    logic [63:0] imd_q, imd_d, pp_ext, full, rnd;
    logic [31:0] word, acc_res;
    logic        acc_ov;

    ibex_mult_pext_sat u_sat (
        .a   (rd_i),
        .b   (imd_q[31:0]),
        .sub (sub_i),
        .sat (sat_i),
        .res (acc_res),
        .ov  (acc_ov)
    );

    // state and intermediate product; reset clears any residue of an aborted op
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            imd_q <= '0;
        end else begin
            state_q <= state_d;
            imd_q <= imd_d;
        end
    end

    // next state, datapath and outputs; reset forces outputs low without waiting for an edge
    always_comb begin
        state_d = state_q;
        imd_d = imd_q;
        b_half_o = 1'b0;
        valid_o = 1'b0;
        ov_o = 1'b0;
        result_o = '0;
        pp_ext = {{15{pp_i[48]}}, pp_i};
        full = imd_q + (pp_ext << 16);
        rnd = full + (round_i ? ROUND_C : 64'd0);
        word = out_lo_i ? full[31:0] : rnd[63:32];
        case (state_q)
            IDLE: begin
                if (mult_en_i && !cycle_count_i[0]) begin
                    valid_o = 1'b1;
                    result_o = single_i;
                end else if (mult_en_i) begin
                    imd_d = pp_ext;
                    state_d = CYC1;
                end
            end
            CYC1: begin
                b_half_o = 1'b1;
                state_d = IDLE;
                if (!mult_en_i) begin
                    imd_d = '0;
                end else if (cycle_count_i[1]) begin
                    imd_d[31:0] = word;
                    state_d = CYC2;
                end else begin
                    valid_o = 1'b1;
                    result_o = word;
                end
            end
            CYC2: begin
                state_d = IDLE;
                if (!mult_en_i) begin
                    imd_d = '0;
                end else begin
                    valid_o = 1'b1;
                    result_o = accum_i ? acc_res : imd_q[31:0];
                    ov_o = accum_i & acc_ov;
                end
            end
            default: state_d = IDLE;
        endcase
        if (rst_i) {b_half_o, valid_o, ov_o, result_o} = '0;
    end
endmodule

// File: tb/tb_ibex_mult_pext_seq.sv
// tb_ibex_mult_pext_seq: directed and random ops against a 64-bit arithmetic reference model
module tb_ibex_mult_pext_seq;
    logic        clk_i = 1'b0, rst_i = 1'b1, mult_en_i = 1'b0;
    logic [1:0]  cycle_count_i = '0;
    logic        accum_i = 0, sub_i = 0, sat_i = 0, round_i = 0, out_lo_i = 0;
    logic [48:0] pp_i;
    logic [31:0] single_i = '0, rd_i = '0, op_a = '0, op_b = '0;
    logic        b_half_o, valid_o, ov_o;
    logic [31:0] result_o;
    int          checks = 0, fails = 0;

    ibex_mult_pext_seq dut (
        .clk_i(clk_i), .rst_i(rst_i), .mult_en_i(mult_en_i), .cycle_count_i(cycle_count_i),
        .accum_i(accum_i), .sub_i(sub_i), .sat_i(sat_i), .round_i(round_i), .out_lo_i(out_lo_i),
        .pp_i(pp_i), .single_i(single_i), .rd_i(rd_i),
        .b_half_o(b_half_o), .result_o(result_o), .valid_o(valid_o), .ov_o(ov_o)
    );

    always #5 clk_i = ~clk_i;

    // 33x16 array: signed A times unsigned Bl or signed Bh
    logic signed [48:0] a_s, bl_s, bh_s;
    assign a_s  = $signed({op_a[31], op_a});
    assign bl_s = $signed({1'b0, op_b[15:0]});
    assign bh_s = $signed(op_b[31:16]);
    assign pp_i = b_half_o ? a_s * bh_s : a_s * bl_s;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic void model(input logic [31:0] a, b, rd, single, input logic [1:0] cnt,
                                  input logic acc, sub, sat, rnd, lo,
                                  output logic [31:0] res, output logic ov, output int cyc);
        longint sa, sb, p, s, w;
        logic [63:0] pr;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p = sa * sb;
        pr = p + (rnd ? 64'h8000_0000 : 64'd0);
        ov = 1'b0;
        if (!cnt[0]) begin
            cyc = 1;
            res = single;
            return;
        end
        res = lo ? p[31:0] : pr[63:32];
        cyc = cnt[1] ? 3 : 2;
        if (!(cnt[1] && acc)) return;
        w = longint'($signed(res));
        s = sub ? longint'($signed(rd)) - w : longint'($signed(rd)) + w;
        if (sat && s > 64'sh7fff_ffff) begin
            res = 32'h7fff_ffff;
            ov = 1'b1;
        end else if (sat && s < -64'sh8000_0000) begin
            res = 32'h8000_0000;
            ov = 1'b1;
        end else begin
            res = s[31:0];
        end
    endfunction

    // run one op starting just after a rising edge; ends just after the edge that retires it
    task automatic run_op(input string tag, input logic [31:0] a, b, rd, single,
                          input logic [1:0] cnt, input logic acc, sub, sat, rnd, lo);
        logic [31:0] er, gr;
        logic eo, go;
        int ec, gc;
        model(a, b, rd, single, cnt, acc, sub, sat, rnd, lo, er, eo, ec);
        op_a = a; op_b = b; rd_i = rd; single_i = single; cycle_count_i = cnt;
        accum_i = acc; sub_i = sub; sat_i = sat; round_i = rnd; out_lo_i = lo;
        mult_en_i = 1'b1;
        gc = 0; gr = 'x; go = 'x;
        for (int n = 1; n <= 4; n++) begin
            @(negedge clk_i);
            if (valid_o) begin
                gc = n; gr = result_o; go = ov_o;
                break;
            end
            @(posedge clk_i); #1;
        end
        if (gc != 0) begin
            @(posedge clk_i); #1;
        end
        chk({tag, ".cycles"}, gc, ec);
        chk({tag, ".result"}, gr, er);
        chk({tag, ".ov"}, {31'd0, go}, {31'd0, eo});
    endtask

    initial begin
        #2;
        chk("rst.valid", {31'd0, valid_o}, 32'd0);
        chk("rst.result", result_o, 32'd0);
        chk("rst.ov_bhalf", {30'd0, ov_o, b_half_o}, 32'd0);
        @(posedge clk_i); #1;
        rst_i = 1'b0;

        run_op("smmul", 32'h4000_0000, 32'h4000_0000, 0, 0, 2'b01, 0, 0, 0, 0, 0);
        run_op("kmmac", 32'h0001_0000, 32'h0020_0000, 32'h7fff_fff0, 0, 2'b11, 1, 0, 1, 0, 0);
        run_op("msubr32", 3, 2, 5, 0, 2'b11, 1, 1, 0, 0, 1);
        run_op("smmulu_r1", 32'h8000, 32'h1_0000, 0, 0, 2'b01, 0, 0, 0, 1, 0);
        run_op("smmulu_r0", 32'h8000, 32'h1_0000, 0, 0, 2'b01, 0, 0, 0, 0, 0);
        run_op("single00", 0, 0, 0, 32'hdead_beef, 2'b00, 0, 0, 0, 0, 0);
        chk("single00.idle", {31'd0, b_half_o}, 32'd0);
        run_op("single10", 0, 0, 0, 32'h1234_5678, 2'b10, 0, 0, 0, 0, 0);
        run_op("noacc", 32'h1234_5678, 32'h9abc_def0, 32'h7fff_ffff, 0, 2'b11, 0, 0, 1, 0, 0);
        run_op("kmmsb_neg", 32'h8000_0000, 32'h7fff_ffff, 32'h8000_0000, 0, 2'b11, 1, 1, 1, 0, 0);

        // abort in CYC1
        op_a = 32'h1111_1111; op_b = 32'h2222_2222; cycle_count_i = 2'b11; accum_i = 0;
        mult_en_i = 1'b1;
        @(posedge clk_i); #1;
        mult_en_i = 1'b0;
        @(negedge clk_i);
        chk("abort.cyc1_valid", {31'd0, valid_o}, 32'd0);
        @(posedge clk_i);
        @(negedge clk_i);
        chk("abort.idle", {30'd0, b_half_o, valid_o}, 32'd0);
        @(posedge clk_i); #1;

        // reset pulse in CYC2 of a saturating op
        op_a = 32'h0001_0000; op_b = 32'h0020_0000; rd_i = 32'h7fff_fff0;
        cycle_count_i = 2'b11; accum_i = 1; sub_i = 0; sat_i = 1; round_i = 0; out_lo_i = 0;
        mult_en_i = 1'b1;
        @(posedge clk_i); @(posedge clk_i); #1;
        chk("rst_mid.pre_valid", {31'd0, valid_o}, 32'd1);
        #2 rst_i = 1'b1;
        #1;
        chk("rst_mid.valid", {31'd0, valid_o}, 32'd0);
        chk("rst_mid.result", result_o, 32'd0);
        chk("rst_mid.ov_bhalf", {30'd0, ov_o, b_half_o}, 32'd0);
        mult_en_i = 1'b0;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        run_op("after_rst", 32'h4000_0000, 32'h4000_0000, 0, 0, 2'b01, 0, 0, 0, 0, 0);

        for (int i = 0; i < 40; i++) begin
            run_op("rand", $urandom, $urandom, $urandom, $urandom, 2'($urandom_range(0, 3)),
                   1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            if ($urandom_range(0, 1) == 1) begin
                mult_en_i = 1'b0;
                @(negedge clk_i);
                chk("rand.idle_valid", {31'd0, valid_o}, 32'd0);
                @(posedge clk_i); #1;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
        $finish;
    end
endmodule
